mine_placer: RTL and testbench
==============================

MINE_PLACER -- requirements
Module: mine_placer

Interface
REQ-001 SHALL have parameter NUM_MINES, default 5: mines placed per game; legal range 1..23.
REQ-002 SHALL have parameter LFSR_SEED, default 16'hACE1: LFSR reset value; must be nonzero.
REQ-003 SHALL have port clka, input, 1: single system clock; all state updates on rising edge.
REQ-004 SHALL have port restart_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: one-cycle placement request from the game controller.
REQ-006 SHALL have port first_cell, input, 5: index 0..24 of the player's first cell; used only under SAFE_FIRST_EN.
REQ-007 SHALL have port qaddr, input, 5: cell index to query.
REQ-008 SHALL have port qmine, output, 1: combinational board[qaddr]; 0 when qaddr > 24.
REQ-009 SHALL have port board, output, 25: registered mine map, bit i = mine in cell i (row-major 5x5).
REQ-010 SHALL have port busy, output, 1: high while CLEAR or PLACE.
REQ-011 SHALL have port place_done, output, 1: level, high in DONE until the next accepted start or reset.

Function
REQ-012 SHALL run a 16-bit Fibonacci LFSR, taps 16,14,13,11, advancing every clka cycle in every state; start timing therefore seeds the board.
REQ-013 SHALL implement states IDLE, CLEAR, PLACE, DONE, held in a 2-bit register.
REQ-014 IDLE: start=1 -> CLEAR; otherwise stay.
REQ-015 CLEAR (one cycle): board<=0, mine counter<=0, place_done<=0; -> PLACE.
REQ-016 PLACE: each cycle candidate c = lfsr[4:0]; c is accepted iff c<=24, board[c]==0 and c is not excluded (REQ-026); acceptance sets board[c] and increments the counter.
REQ-017 PLACE -> DONE in the cycle after the counter reaches NUM_MINES; no further bits are set after acceptance of the NUM_MINES-th mine.
REQ-018 DONE: place_done=1, busy=0; start=1 -> CLEAR, with place_done low from the next cycle.
REQ-019 start SHALL be ignored while in CLEAR or PLACE.
REQ-020 Mine counter SHALL be 5 bits; popcount(board) SHALL equal the counter at all times.
REQ-021 Latency SHALL be start sampled at edge N -> busy=1 after edge N+1 -> place_done=1 no earlier than edge N+2+NUM_MINES.
REQ-022 board SHALL be stable whenever place_done=1.

Reset
REQ-023 restart_n low SHALL immediately force state=IDLE, lfsr=LFSR_SEED, board=0, counter=0, busy=0, place_done=0, in any state including mid-PLACE.
REQ-024 After restart_n deasserts, the first rising edge SHALL advance the LFSR and sample start normally.

Configuration
REQ-025 Macro SAFE_FIRST_EN SHALL be the only compile-time option.
REQ-026 With SAFE_FIRST_EN defined: first_cell SHALL be sampled in CLEAR, and the candidate equal to the sampled value SHALL always be rejected; board[first_cell] is guaranteed 0 in DONE.
REQ-027 Without SAFE_FIRST_EN: first_cell SHALL be ignored and every cell 0..24 may receive a mine.

Verification
REQ-028 Reset: restart_n=0 then 1 -> board=25'h0, busy=0, place_done=0, state IDLE, LFSR=16'hACE1.
REQ-029 Start at 10th edge after reset, NUM_MINES=5 -> busy high next cycle, place_done rises, popcount(board)=5, board equals a cycle-accurate LFSR reference model.
REQ-030 Pulse start again mid-PLACE -> ignored; board and counter sequence identical to an uninterrupted run.
REQ-031 restart_n low while counter=3 in PLACE -> board=0, busy=0, place_done=0 immediately; no further mines.
REQ-032 In DONE pulse start -> place_done 0 next cycle, one CLEAR cycle with board=0, new 5-mine board; qmine matches board for all qaddr 0..31 (qaddr 25..31 -> 0).
REQ-033 SAFE_FIRST_EN, first_cell=12, 200 games at random start times with NUM_MINES=23 -> board[12]=0 and popcount=23 every game.

Source files
------------

// File: rtl/mine_placer_if.sv
// Bus between the game controller and mine_placer: placement request, board query and
// status, plus debug visibility of the placer FSM state, LFSR and mine counter.
interface mine_placer_if;
    logic        start;
    logic [4:0]  first_cell;
    logic [4:0]  qaddr;
    logic        qmine;
    logic [24:0] board;
    logic        busy;
    logic        place_done;
    logic [1:0]  dbg_state;
    logic [15:0] dbg_lfsr;
    logic [4:0]  dbg_count;

    modport master (
        output start, first_cell, qaddr,
        input  qmine, board, busy, place_done, dbg_state, dbg_lfsr, dbg_count
    );

    modport slave (
        input  start, first_cell, qaddr,
        output qmine, board, busy, place_done, dbg_state, dbg_lfsr, dbg_count
    );
endinterface

// File: rtl/mine_placer.sv
// Places NUM_MINES mines on a 5x5 board using a free-running 16-bit LFSR.
// Optional macro SAFE_FIRST_EN keeps the player's first cell free of mines.
module mine_placer #(
    parameter int          NUM_MINES = 5,         // legal range 1..23
    parameter logic [15:0] LFSR_SEED = 16'hACE1   // must be nonzero
) (
    input  logic        clka,
    input  logic        restart_n,
    mine_placer_if.slave bus
);

    // Handshake: start is a one-cycle request, accepted only in IDLE or DONE and ignored
    // while busy; place_done is a level that holds in DONE until the next accepted start.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        PLACE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [4:0] TARGET = 5'(NUM_MINES);

    state_t      state, state_next;
    logic [15:0] lfsr;
    logic        lfsr_fb;
    logic [24:0] board_q, board_next;
    logic [4:0]  count_q, count_next;
    logic [31:0] board_ext;
    logic [4:0]  cand;
    logic        cand_free;
    logic        excluded;

    // Taps 16,14,13,11 counted from 1; the register shifts toward the MSB.
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end

`ifdef SAFE_FIRST_EN
    logic [4:0] first_q;

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            first_q <= '0;
        end else if (state == CLEAR) begin
            first_q <= bus.first_cell;
        end
    end

    assign excluded = (cand == first_q);
`else
    logic unused_first_cell;

    assign unused_first_cell = ^bus.first_cell;
    assign excluded          = 1'b0;
`endif

    // Zero-extended board so any 5-bit index (25..31 included) reads a defined 0.
    assign board_ext = {7'd0, board_q};
    assign cand      = lfsr[4:0];
    assign cand_free = (cand <= 5'd24) && !board_ext[cand] && !excluded;

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            state   <= IDLE;
            board_q <= '0;
            count_q <= '0;
        end else begin
            state   <= state_next;
            board_q <= board_next;
            count_q <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        board_next = board_q;
        count_next = count_q;
        case (state)
            IDLE, DONE: begin
                // Clearing on acceptance makes the board read zero throughout CLEAR.
                if (bus.start) begin
                    state_next = CLEAR;
                    board_next = '0;
                    count_next = '0;
                end
            end
            CLEAR: begin
                board_next = '0;
                count_next = '0;
                state_next = PLACE;
            end
            PLACE: begin
                if (count_q == TARGET) begin
                    state_next = DONE;
                end else if (cand_free) begin
                    board_next = board_q | (25'd1 << cand);
                    count_next = count_q + 5'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.board      = board_q;
    assign bus.qmine      = board_ext[bus.qaddr];
    assign bus.busy       = (state == CLEAR) || (state == PLACE);
    assign bus.place_done = (state == DONE);
    assign bus.dbg_state  = state;
    assign bus.dbg_lfsr   = lfsr;
    assign bus.dbg_count  = count_q;

endmodule

// File: tb/tb_mine_placer.sv
// Self-checking bench for mine_placer: table of game scenarios plus randomized games,
// all compared against a behavioural placement model driven by a reference LFSR.
`timescale 1ns/1ps
module tb_mine_placer;

`ifdef SAFE_FIRST_EN
    localparam int NM         = 23;
    localparam bit SAFE       = 1'b1;
    localparam int RAND_GAMES = 200;
`else
    localparam int NM         = 5;
    localparam bit SAFE       = 1'b0;
    localparam int RAND_GAMES = 40;
`endif
    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [1:0] ST_IDLE = 2'd0, ST_CLEAR = 2'd1, ST_PLACE = 2'd2, ST_DONE = 2'd3;

    logic clka      = 1'b0;
    logic restart_n = 1'b1;

    mine_placer_if bus();

    mine_placer #(.NUM_MINES(NM), .LFSR_SEED(SEED)) dut (
        .clka      (clka),
        .restart_n (restart_n),
        .bus       (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clka = ~clka;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    int checks = 0;
    int errors = 0;
    logic [24:0] exp_q[$];
    logic [24:0] last_board;
    logic [15:0] m_lfsr;

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        // Fibonacci polynomial x^16 + x^14 + x^13 + x^11 + 1
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    always @(posedge clka or negedge restart_n) begin
        if (!restart_n) m_lfsr <= SEED;
        else            m_lfsr <= lfsr_next(m_lfsr);
    end

    function automatic int popcount(input logic [24:0] b);
        int n = 0;
        for (int i = 0; i < 25; i++) n += int'(b[i]);
        return n;
    endfunction

    // Expected board after each PLACE cycle, given the LFSR value present when start is sampled.
    task automatic build_model(input logic [15:0] l0, input logic [4:0] fc, output bit ok);
        logic [15:0] lf;
        logic [31:0] b;
        int cnt, steps;
        logic [4:0] c;
        exp_q.delete();
        lf = lfsr_next(lfsr_next(l0));
        b = '0;
        cnt = 0;
        steps = 0;
        while (cnt < NM && steps < 5000) begin
            c = lf[4:0];
            if (c <= 5'd24 && b[c] == 1'b0 && !(SAFE && c == fc)) begin
                b[c] = 1'b1;
                cnt++;
            end
            exp_q.push_back(b[24:0]);
            lf = lfsr_next(lf);
            steps++;
        end
        ok = (cnt == NM);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic do_abort();
        @(negedge clka);
        restart_n = 1'b0;
        #1;
        check("abort_board", 32'(bus.board), 32'h0);
        check("abort_busy", 32'(bus.busy), 32'h0);
        check("abort_done", 32'(bus.place_done), 32'h0);
        check("abort_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        check("abort_count", 32'(bus.dbg_count), 32'h0);
        check("abort_lfsr", 32'(bus.dbg_lfsr), 32'(SEED));
        repeat (2) @(posedge clka);
        #1;
        check("abort_hold_board", 32'(bus.board), 32'h0);
        @(negedge clka);
        restart_n = 1'b1;
        @(posedge clka);
        #1;
        check("abort_first_edge_lfsr", 32'(bus.dbg_lfsr), 32'(lfsr_next(SEED)));
        check("abort_first_edge_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    endtask

    task automatic run_game(input int idle, input bit mid, input int abort_cnt,
                            input logic [4:0] fc, input int exp_mines);
        bit ok;
        logic [24:0] fin;
        repeat (idle) @(posedge clka);
        @(negedge clka);
        if (bus.place_done) check("done_board_stable", 32'(bus.board), 32'(last_board));
        check("lfsr_track", 32'(bus.dbg_lfsr), 32'(m_lfsr));
        bus.start      = 1'b1;
        bus.first_cell = fc;
        build_model(m_lfsr, fc, ok);
        check("model_converged", 32'(ok), 32'h1);
        @(posedge clka);
        #1;
        check("clear_busy", 32'(bus.busy), 32'h1);
        check("clear_done_low", 32'(bus.place_done), 32'h0);
        check("clear_board", 32'(bus.board), 32'h0);
        check("clear_state", 32'(bus.dbg_state), 32'(ST_CLEAR));
        @(negedge clka);
        bus.start = mid;
        @(posedge clka);
        #1;
        check("place_entry_state", 32'(bus.dbg_state), 32'(ST_PLACE));
        check("place_entry_board", 32'(bus.board), 32'h0);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clka);
            bus.start = mid && (i == 1);
            @(posedge clka);
            #1;
            check("place_board", 32'(bus.board), 32'(exp_q[i]));
            check("place_count", 32'(bus.dbg_count), 32'(popcount(exp_q[i])));
            check("place_busy", 32'(bus.busy), 32'h1);
            check("place_done_low", 32'(bus.place_done), 32'h0);
            if (abort_cnt > 0 && popcount(exp_q[i]) == abort_cnt) begin
                bus.start = 1'b0;
                do_abort();
                return;
            end
        end
        fin = (exp_q.size() > 0) ? exp_q[exp_q.size() - 1] : 25'h0;
        @(negedge clka);
        bus.start = 1'b0;
        @(posedge clka);
        #1;
        check("done_state", 32'(bus.dbg_state), 32'(ST_DONE));
        check("done_level", 32'(bus.place_done), 32'h1);
        check("done_busy", 32'(bus.busy), 32'h0);
        check("done_board", 32'(bus.board), 32'(fin));
        check("done_popcount", 32'(popcount(bus.board)), 32'(exp_mines));
        if (SAFE) check("safe_first_cell", 32'(bus.board[fc]), 32'h0);
        for (int q = 0; q < 32; q++) begin
            bus.qaddr = 5'(q);
            #0.1;
            check("qmine", 32'(bus.qmine), (q <= 24) ? 32'(fin[q]) : 32'h0);
        end
        last_board = fin;
    endtask

    // ---------------- stimulus table ----------------
    typedef struct {
        int         idle;
        bit         mid;
        int         abort_cnt;
        logic [4:0] fc;
        int         exp_mines;
    } game_vec_t;

    game_vec_t vecs[5];

    initial begin
        vecs[0] = '{idle: 9, mid: 1'b0, abort_cnt: 0, fc: 5'd12, exp_mines: NM};
        vecs[1] = '{idle: 0, mid: 1'b1, abort_cnt: 0, fc: 5'd12, exp_mines: NM};
        vecs[2] = '{idle: 3, mid: 1'b1, abort_cnt: 0, fc: 5'd12, exp_mines: NM};
        vecs[3] = '{idle: 1, mid: 1'b0, abort_cnt: 3, fc: 5'd12, exp_mines: NM};
        vecs[4] = '{idle: 5, mid: 1'b0, abort_cnt: 0, fc: 5'd12, exp_mines: NM};

        bus.start      = 1'b0;
        bus.first_cell = 5'd0;
        bus.qaddr      = 5'd0;
        last_board     = '0;

        #2 restart_n = 1'b0;
        repeat (3) @(posedge clka);
        #1;
        check("reset_board", 32'(bus.board), 32'h0);
        check("reset_busy", 32'(bus.busy), 32'h0);
        check("reset_done", 32'(bus.place_done), 32'h0);
        check("reset_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        check("reset_lfsr", 32'(bus.dbg_lfsr), 32'(SEED));
        check("reset_count", 32'(bus.dbg_count), 32'h0);
        @(negedge clka);
        restart_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            run_game(vecs[v].idle, vecs[v].mid, vecs[v].abort_cnt, vecs[v].fc, vecs[v].exp_mines);
        end

        for (int g = 0; g < RAND_GAMES; g++) begin
            run_game($urandom_range(0, 20), 1'($urandom_range(0, 1)), 0,
                     SAFE ? 5'd12 : 5'($urandom_range(0, 24)), NM);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
